// File: rtl/syscon_pkg.sv
// Shared constants for the system clock/reset controller.
// Stretch length helper: cycles rst stays high after a request releases.
package syscon_pkg;

  localparam int SYSCON_CNT_W_DEF = 5;

  function automatic int syscon_stretch_len(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sys_clk_rst_ctrl_if.sv
// Wishbone system clock/reset bundle; master drives it, every consumer uses slave.
// Pure wiring, no latency or backpressure.
interface sys_clk_rst_ctrl_if;
  logic clk_i;
  logic rst_i;
  logic nrst_i;

  modport master (output clk_i, output rst_i, output nrst_i);
  modport slave  (input  clk_i, input  rst_i, input  nrst_i);
endinterface

// File: rtl/syscon_sync2.sv
// Two-flop synchronizer for an asynchronous level, powering up at 0.
// Latency: 2 edges; no backpressure.
module syscon_sync2 (
  input  logic i_clk,
  input  logic i_d,
  output logic o_q
);

  // Power-up 0 makes the synced input read as "reset requested" until settled.
  logic [1:0] r_sync = 2'b00;

  always_ff @(posedge i_clk) begin
    r_sync <= {r_sync[0], i_d};
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/sys_clk_rst_ctrl.sv
// Board clock pass-through plus glitch-free stretched Wishbone reset; SYSCON_RST_SYNC_EN adds input synchronizers.
// Latency: assert 1 edge, hold 2^CNT_W-1 edges after release (+2 each with sync); no backpressure.
module sys_clk_rst_ctrl
  import syscon_pkg::*;
#(
  parameter int CNT_W = SYSCON_CNT_W_DEF
) (
  input  logic                 clk_sys_i,
  input  logic                 nrst_sys_i,
  input  logic                 pll_locked_i,
  sys_clk_rst_ctrl_if.master   sys
);

  logic             w_nrst;
  logic             w_locked;
  logic             w_req;
  logic [CNT_W-1:0] r_cnt = CNT_W'(1);

`ifdef SYSCON_RST_SYNC_EN
  syscon_sync2 u_sync_nrst (
    .i_clk (clk_sys_i),
    .i_d   (nrst_sys_i),
    .o_q   (w_nrst)
  );

  syscon_sync2 u_sync_lock (
    .i_clk (clk_sys_i),
    .i_d   (pll_locked_i),
    .o_q   (w_locked)
  );
`else
  assign w_nrst   = nrst_sys_i;
  assign w_locked = pll_locked_i;
`endif

  assign w_req = ~w_nrst | ~w_locked;

  // Counter wraps to 0 to end the stretch; any request restarts it at 1.
  always_ff @(posedge clk_sys_i) begin
    if (w_req) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign sys.clk_i  = clk_sys_i;
  assign sys.rst_i  = |r_cnt;
  assign sys.nrst_i = ~(|r_cnt);

endmodule

// File: tb/tb_sys_clk_rst_ctrl.sv
// Bench for sys_clk_rst_ctrl: vector table, latency/stretch sequences and random requests
// checked against an edges-since-last-request reference model.
module tb_sys_clk_rst_ctrl;
  import syscon_pkg::*;

  localparam int CNT_W   = SYSCON_CNT_W_DEF;
  localparam int STRETCH = (1 << CNT_W) - 1;
`ifdef SYSCON_RST_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk_sys;
  logic nrst_sys;
  logic pll_locked;

  sys_clk_rst_ctrl_if sys ();

  sys_clk_rst_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_sys_i    (clk_sys),
    .nrst_sys_i   (nrst_sys),
    .pll_locked_i (pll_locked),
    .sys          (sys)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;

  // Reference model: reset is high while fewer than STRETCH edges have passed
  // since the most recent effective request; power-up acts like a request at edge -1.
  int   edge_k   = 0;
  int   last_req = -1;
  logic exp_rst  = 1'b1;
  logic raw_hist [$];

  typedef struct {
    logic nrst;
    logic pll;
    int   cycles;
    logic exp_end;
    logic exp_end_sync;
  } vec_t;

  vec_t tbl [$];

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0b required=%0b", name, edge_k, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic raw_req);
    logic eff;
    raw_hist.push_back(raw_req);
    if (SYNC_LAT == 0) eff = raw_req;
    else if (edge_k < SYNC_LAT) eff = 1'b1;
    else eff = raw_hist[edge_k - SYNC_LAT];
    if (eff) last_req = edge_k;
    exp_rst = ((edge_k - last_req) < STRETCH);
    edge_k++;
  endtask

  task automatic run_cycle(input logic n, input logic p);
    nrst_sys   = n;
    pll_locked = p;
    model_edge(~n | ~p);
    @(posedge clk_sys);
    #1;
    check_bit("clk_i_high", sys.clk_i, 1'b1);
    @(negedge clk_sys);
    check_bit("clk_i_low", sys.clk_i, 1'b0);
    check_bit("rst_i", sys.rst_i, exp_rst);
    check_bit("nrst_i", sys.nrst_i, ~exp_rst);
  endtask

  initial begin
    int lat;
    int hi;
    nrst_sys   = 1'b1;
    pll_locked = 1'b1;
    #1;
    check_bit("powerup_rst", sys.rst_i, 1'b1);
    check_bit("powerup_nrst", sys.nrst_i, 1'b0);

    tbl.push_back('{1'b1, 1'b1, 40,  1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1,   1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 30,  1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1,   1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 5,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 100, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 30,  1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1,   1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 5,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1,   1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 20,  1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1,   1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 30,  1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1,   1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 5,   1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 3,   1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 30,  1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1,   1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 5,   1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 2,   1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 40,  1'b0, 1'b0});

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].cycles; c++) run_cycle(tbl[i].nrst, tbl[i].pll);
      check_bit($sformatf("row%0d_end", i), sys.rst_i,
                (SYNC_LAT == 0) ? tbl[i].exp_end : tbl[i].exp_end_sync);
    end

    // Single-cycle pulse: measure assertion latency and stretch length directly.
    run_cycle(1'b0, 1'b1);
    lat = 1;
    while (!sys.rst_i && lat < 10) begin
      run_cycle(1'b1, 1'b1);
      lat++;
    end
    check_int("assert_latency", lat, 1 + SYNC_LAT);
    hi = sys.rst_i ? 1 : 0;
    while (sys.rst_i && hi < 200) begin
      run_cycle(1'b1, 1'b1);
      if (sys.rst_i) hi++;
    end
    check_int("stretch_len", hi, syscon_stretch_len(CNT_W));
    for (int c = 0; c < 5; c++) run_cycle(1'b1, 1'b1);
    check_bit("idle_after_pulse", sys.rst_i, 1'b0);

    // Random requests, with idle gaps so the stretch can fully expire.
    for (int c = 0; c < 600; c++) begin
      if ((c % 150) > 100) run_cycle(1'b1, 1'b1);
      else run_cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 59) != 0));
    end
    for (int c = 0; c < 40; c++) run_cycle(1'b1, 1'b1);
    check_bit("final_idle", sys.rst_i, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout edge=%0d", edge_k);
    $fatal(1, "timeout");
  end

endmodule
